// File: rtl/bcp_pkg.sv
// bcp_pkg -- shared definitions for the BCP scan engine.
//   * clause word field layout: a clause word is two VAR_NUM-wide fields,
//     the positive-literal mask in field BCP_POS_FIELD (upper) and the
//     negative-literal mask in field BCP_NEG_FIELD (lower)
//   * FSM state enum (IDLE, SCAN, DONE)
//   * trail entry struct used when BCP_TRAIL_EN is defined
//   * bcp_eval_clause(): per-lane clause evaluator (falsified / unit detect)
// The evaluator works on BCP_MAX_VAR-wide vectors; callers zero-extend their
// VAR_NUM-wide fields, so engines with VAR_NUM up to BCP_MAX_VAR share it.
package bcp_pkg;

  localparam int BCP_MAX_VAR   = 32;
  localparam int BCP_VIDX_W    = 5;   // enough to index BCP_MAX_VAR variables
  localparam int BCP_CIDX_W    = 8;   // clause index width stored in the trail
  localparam int BCP_POS_FIELD = 1;
  localparam int BCP_NEG_FIELD = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } bcp_state_t;

  typedef struct packed {
    logic [BCP_VIDX_W-1:0] var_idx;
    logic                  value;
    logic [BCP_CIDX_W-1:0] clause_idx;
  } bcp_trail_t;

  typedef struct packed {
    logic                  falsified;
    logic                  unit;
    logic [BCP_VIDX_W-1:0] unit_var;
    logic                  unit_val;
  } bcp_eval_t;

  // A clause is satisfied if any assigned literal is true. Otherwise it is
  // falsified with no free literals, or unit with exactly one free literal.
  // The implied value of a unit literal is its positive-mask bit.
  function automatic bcp_eval_t bcp_eval_clause(
    input logic [BCP_MAX_VAR-1:0] pos,
    input logic [BCP_MAX_VAR-1:0] neg,
    input logic [BCP_MAX_VAR-1:0] asg,
    input logic [BCP_MAX_VAR-1:0] free
  );
    bcp_eval_t              r;
    logic                   sat;
    logic [BCP_MAX_VAR-1:0] free_lits;
    logic                   found;
    logic                   multi;
    r         = '0;
    found     = 1'b0;
    multi     = 1'b0;
    sat       = (|(pos & ~free & asg)) | (|(neg & ~free & ~asg));
    free_lits = (pos | neg) & free;
    for (int i = 0; i < BCP_MAX_VAR; i++) begin
      if (free_lits[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found      = 1'b1;
          r.unit_var = i[BCP_VIDX_W-1:0];
          r.unit_val = pos[i];
        end
      end
    end
    r.falsified = !sat && !found;
    r.unit      = !sat && found && !multi;
    return r;
  endfunction

endpackage

// File: rtl/bcp_trail_fifo.sv
// bcp_trail_fifo -- small synchronous FIFO holding the implication trail.
// Ports: clock, reset (sync, active-low), clear (empties the FIFO),
//        push_valid/push_data (write; dropped when full),
//        pop_ready/pop_valid/pop_data (read side).
// Handshake: an entry leaves when pop_valid && pop_ready on a rising edge;
// pop_data is stable while pop_valid is high and pop_ready is low.
module bcp_trail_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign do_push   = push_valid && (count != CW'(DEPTH));
  assign do_pop    = pop_valid && pop_ready;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/bcp_scan_engine.sv
// bcp_scan_engine -- iterative Boolean Constraint Propagation engine.
// Scans a local clause store LANES clauses per cycle against a working
// assignment, applies one implication per cycle, and repeats full passes
// until a fixed point or a falsified clause.
// Ports:
//   clock, reset (sync, active-low)
//   clause_we/clause_addr/clause_wdata : clause store write (IDLE only)
//   start, assignment, free            : run request (IDLE only)
//   busy, done                         : run status; done pulses one cycle
//   implication, impl_value, implication_exist, conflict, conflict_clause,
//   pass_count                         : run results, held until next start
//   trail_valid/trail_data/trail_ready : implication trail, only when the
//                                        BCP_TRAIL_EN macro is defined
// Handshake: start is a single-cycle request accepted only while busy is low;
// results are valid from the cycle done is high until the next accepted start.
// Requires CLAUSE_NUM >= 2 and VAR_NUM <= bcp_pkg::BCP_MAX_VAR.
module bcp_scan_engine
  import bcp_pkg::*;
#(
  parameter int VAR_NUM    = 8,
  parameter int CLAUSE_NUM = 8,
  parameter int LANES      = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clause_we,
  input  logic [$clog2(CLAUSE_NUM)-1:0]   clause_addr,
  input  logic [2*VAR_NUM-1:0]            clause_wdata,
  input  logic                            start,
  input  logic [VAR_NUM-1:0]              assignment,
  input  logic [VAR_NUM-1:0]              free,
  output logic                            busy,
  output logic                            done,
  output logic [VAR_NUM-1:0]              implication,
  output logic [VAR_NUM-1:0]              impl_value,
  output logic                            implication_exist,
  output logic                            conflict,
  output logic [$clog2(CLAUSE_NUM)-1:0]   conflict_clause,
  output logic [$clog2(VAR_NUM+2)-1:0]    pass_count
`ifdef BCP_TRAIL_EN
  ,
  output logic                            trail_valid,
  output logic [$bits(bcp_trail_t)-1:0]   trail_data,
  input  logic                            trail_ready
`endif
);

  localparam int AW   = $clog2(CLAUSE_NUM);
  localparam int PW   = $clog2(VAR_NUM + 2);
  localparam int G    = (CLAUSE_NUM + LANES - 1) / LANES;
  localparam int LAST = (G - 1) * LANES;   // ptr value of the last group

  logic [2*VAR_NUM-1:0] store [CLAUSE_NUM];
  logic [CLAUSE_NUM-1:0] store_valid;

  bcp_state_t        state;
  bcp_state_t        state_next;
  logic [AW-1:0]     ptr;
  logic              changed;
  logic [VAR_NUM-1:0] wasg;
  logic [VAR_NUM-1:0] wfree;

  logic              is_last;
  logic              hit_conf;
  logic              hit_unit;
  logic [AW-1:0]     conf_idx;
  logic [BCP_VIDX_W-1:0] unit_var_sel;
  logic              unit_val_sel;
  logic [VAR_NUM-1:0] unit_mask;
  logic [AW:0]       lane_pos;
  logic [2*VAR_NUM-1:0] lane_word;
  bcp_eval_t         lane_ev;
`ifdef BCP_TRAIL_EN
  logic [AW-1:0]     unit_clause;
`endif

  assign implication_exist = |implication;
  assign is_last           = (ptr == AW'(LAST));
  assign unit_mask         = VAR_NUM'(1) << unit_var_sel;

  // Lanes are walked from highest to lowest so the lowest-index hit wins.
  // Out-of-range lanes, invalid entries and all-zero words never hit.
  always_comb begin
    hit_conf     = 1'b0;
    hit_unit     = 1'b0;
    conf_idx     = '0;
    unit_var_sel = '0;
    unit_val_sel = 1'b0;
    lane_pos     = '0;
    lane_word    = '0;
    lane_ev      = '0;
`ifdef BCP_TRAIL_EN
    unit_clause  = '0;
`endif
    for (int l = LANES - 1; l >= 0; l--) begin
      lane_pos  = {1'b0, ptr} + (AW + 1)'(l);
      lane_word = store[lane_pos[AW-1:0]];
      lane_ev   = bcp_eval_clause(
        BCP_MAX_VAR'(lane_word[BCP_POS_FIELD*VAR_NUM +: VAR_NUM]),
        BCP_MAX_VAR'(lane_word[BCP_NEG_FIELD*VAR_NUM +: VAR_NUM]),
        BCP_MAX_VAR'(wasg),
        BCP_MAX_VAR'(wfree));
      if ((lane_pos < (AW + 1)'(CLAUSE_NUM)) && store_valid[lane_pos[AW-1:0]] &&
          (lane_word != '0)) begin
        if (lane_ev.falsified) begin
          hit_conf = 1'b1;
          conf_idx = lane_pos[AW-1:0];
        end
        if (lane_ev.unit) begin
          hit_unit     = 1'b1;
          unit_var_sel = lane_ev.unit_var;
          unit_val_sel = lane_ev.unit_val;
`ifdef BCP_TRAIL_EN
          unit_clause  = lane_pos[AW-1:0];
`endif
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        if (hit_conf) begin
          state_next = DONE;
        end else if (!hit_unit && is_last && !changed) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      ptr             <= '0;
      changed         <= 1'b0;
      wasg            <= '0;
      wfree           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      implication     <= '0;
      impl_value      <= '0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      pass_count      <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wasg            <= assignment;
            wfree           <= free;
            implication     <= '0;
            impl_value      <= '0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            pass_count      <= '0;
            ptr             <= '0;
            changed         <= 1'b0;
            busy            <= 1'b1;
          end
        end
        SCAN: begin
          if (hit_conf) begin
            conflict        <= 1'b1;
            conflict_clause <= conf_idx;
          end else if (hit_unit) begin
            // ptr is held so the same group sees the new assignment.
            wfree       <= wfree & ~unit_mask;
            wasg        <= unit_val_sel ? (wasg | unit_mask) : (wasg & ~unit_mask);
            implication <= implication | unit_mask;
            impl_value  <= unit_val_sel ? (impl_value | unit_mask) : (impl_value & ~unit_mask);
            changed     <= 1'b1;
          end else if (!is_last) begin
            ptr <= ptr + AW'(LANES);
          end else begin
            pass_count <= pass_count + PW'(1);
            if (changed) begin
              changed <= 1'b0;
              ptr     <= '0;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Writes land in IDLE, including the cycle start is accepted, so a run
  // always sees a write issued alongside its start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      store_valid <= '0;
    end else if (clause_we && (state == IDLE)) begin
      store_valid[clause_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && clause_we && (state == IDLE)) begin
      store[clause_addr] <= clause_wdata;
    end
  end

`ifdef BCP_TRAIL_EN
  bcp_trail_t trail_in;

  assign trail_in = '{var_idx:    unit_var_sel,
                      value:      unit_val_sel,
                      clause_idx: BCP_CIDX_W'(unit_clause)};

  bcp_trail_fifo #(
    .DEPTH(VAR_NUM),
    .WIDTH($bits(bcp_trail_t))
  ) u_trail (
    .clock     (clock),
    .reset     (reset),
    .clear     ((state == IDLE) && start),
    .push_valid((state == SCAN) && !hit_conf && hit_unit),
    .push_data (trail_in),
    .pop_ready (trail_ready),
    .pop_valid (trail_valid),
    .pop_data  (trail_data)
  );
`endif

endmodule

// File: tb/tb_bcp_scan_engine.sv
// tb_bcp_scan_engine -- directed bench for bcp_scan_engine (defaults 8/8/2).
// Each run pushes its expected result into exp_q; the monitor pops and
// compares whenever done is seen, including start-to-done latency in edges.
module tb_bcp_scan_engine;

  localparam int EW = 48;

  logic        clock = 1'b0;
  logic        reset;
  logic        clause_we;
  logic [2:0]  clause_addr;
  logic [15:0] clause_wdata;
  logic        start;
  logic [7:0]  assignment;
  logic [7:0]  free;
  logic        busy;
  logic        done;
  logic [7:0]  implication;
  logic [7:0]  impl_value;
  logic        implication_exist;
  logic        conflict;
  logic [2:0]  conflict_clause;
  logic [3:0]  pass_count;
`ifdef BCP_TRAIL_EN
  logic        trail_valid;
  logic [13:0] trail_data;
  logic        trail_ready = 1'b0;
`endif

  bcp_scan_engine #(
    .VAR_NUM(8), .CLAUSE_NUM(8), .LANES(2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .clause_we        (clause_we),
    .clause_addr      (clause_addr),
    .clause_wdata     (clause_wdata),
    .start            (start),
    .assignment       (assignment),
    .free             (free),
    .busy             (busy),
    .done             (done),
    .implication      (implication),
    .impl_value       (impl_value),
    .implication_exist(implication_exist),
    .conflict         (conflict),
    .conflict_clause  (conflict_clause),
    .pass_count       (pass_count)
`ifdef BCP_TRAIL_EN
    ,
    .trail_valid      (trail_valid),
    .trail_data       (trail_data),
    .trail_ready      (trail_ready)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [15:0]   img [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {start cycle, latency, implication, impl_value, conflict, clause, passes}
  function automatic logic [EW-1:0] mk_exp(input int sc, input int lat,
                                           input logic [7:0] impl, input logic [7:0] val,
                                           input logic cf, input logic [2:0] cc,
                                           input logic [3:0] pc);
    return {16'(sc), 8'(lat), impl, val, cf, cc, pc};
  endfunction

  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done seen at cycle %0d, no run expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("latency",           32'(cyc - int'(e[47:32])), 32'(e[31:24]));
        check("implication",       32'(implication),          32'(e[23:16]));
        check("impl_value",        32'(impl_value & e[23:16]), 32'(e[15:8]));
        check("implication_exist", 32'(implication_exist),    32'(|e[23:16]));
        check("conflict",          32'(conflict),             32'(e[7]));
        if (e[7]) check("conflict_clause", 32'(conflict_clause), 32'(e[6:4]));
        check("pass_count",        32'(pass_count),           32'(e[3:0]));
        check("busy_at_done",      32'(busy),                 32'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_img();
    for (int i = 0; i < 8; i++) img[i] = 16'h0000;
  endtask

  task automatic load_store();
    for (int i = 0; i < 8; i++) begin
      clause_we    = 1'b1;
      clause_addr  = 3'(i);
      clause_wdata = img[i];
      @(negedge clock);
    end
    clause_we = 1'b0;
  endtask

  task automatic run_case(input logic [7:0] asg, input logic [7:0] fr,
                          input logic [7:0] impl, input logic [7:0] val,
                          input logic cf, input logic [2:0] cc,
                          input logic [3:0] pc, input int lat);
    int n;
    assignment = asg;
    free       = fr;
    start      = 1'b1;
    exp_q.push_back(mk_exp(cyc, lat, impl, val, cf, cc, pc));
    @(negedge clock);
    start     = 1'b0;
    clause_we = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", n);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        32'(busy),              32'(0));
    check({tag, "_done"},        32'(done),              32'(0));
    check({tag, "_implication"}, 32'(implication),       32'(0));
    check({tag, "_impl_value"},  32'(impl_value),        32'(0));
    check({tag, "_exist"},       32'(implication_exist), 32'(0));
    check({tag, "_conflict"},    32'(conflict),          32'(0));
    check({tag, "_clause"},      32'(conflict_clause),   32'(0));
    check({tag, "_passes"},      32'(pass_count),        32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b0;
    clause_we    = 1'b0;
    clause_addr  = '0;
    clause_wdata = '0;
    start        = 1'b0;
    assignment   = '0;
    free         = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    // Unit on x5 from a positive clause; second pass confirms fixed point.
    clear_img();
    img[0] = 16'hE000;
    load_store();
    run_case(8'h00, 8'h20, 8'h20, 8'h20, 1'b0, 3'd0, 4'd2, 11);

    // Same clause fully assigned false: immediate conflict.
    run_case(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd0, 4'd0, 3);

    // Chain x0 -> x1 (clause 5) -> x2 (clause 0), three passes.
    clear_img();
    img[0] = 16'h0402;
    img[5] = 16'h0201;
    load_store();
    run_case(8'h01, 8'hFE, 8'h06, 8'h06, 1'b0, 3'd0, 4'd3, 16);

    // Same-group clash; clause 1 is written in the same cycle as start.
    clear_img();
    img[0] = 16'h0800;
    load_store();
    clause_we    = 1'b1;
    clause_addr  = 3'd1;
    clause_wdata = 16'h0008;
    run_case(8'h00, 8'h08, 8'h08, 8'h08, 1'b1, 3'd1, 4'd0, 4);

    // Negative-literal unit in lane 1 of group 1: x1 implied false.
    clear_img();
    img[3] = 16'h0003;
    load_store();
    run_case(8'h01, 8'h02, 8'h02, 8'h00, 1'b0, 3'd0, 4'd2, 11);

    // Every clause satisfied: minimum latency G+2 = 6.
    for (int i = 0; i < 8; i++) img[i] = 16'h0100;
    load_store();
    run_case(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd1, 6);

    // Reset in the middle of a run, after the first implication lands.
    clear_img();
    img[0] = 16'hE000;
    load_store();
    assignment = 8'h00;
    free       = 8'h20;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("mid_run_implication", 32'(implication), 32'(8'h20));
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("mid_reset");
    reset = 1'b1;
    @(negedge clock);
    // Store was invalidated: same request now finds nothing.
    run_case(8'h00, 8'h20, 8'h00, 8'h00, 1'b0, 3'd0, 4'd1, 6);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcp_scan_engine.md
# bcp_scan_engine

Sequential Boolean Constraint Propagation engine for the hardware SAT datapath. It holds a local clause store and scans it LANES clauses per cycle against a working assignment. Each implication it finds is applied immediately, and it repeats full passes until a fixed point or a conflict is reached. It replaces the single-clause combinational unit-detect check with an iterative, parametrised engine driven by a start/done handshake.

## Interface
- VAR_NUM, 8, number of variables; var i is bit i of every vector
- CLAUSE_NUM, 8, clause store depth
- LANES, 2, clauses evaluated per cycle; 1..CLAUSE_NUM
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; engine reset when sampled 0
- clause_we  in  1  write clause store (ignored while busy)
- clause_addr  in  $clog2(CLAUSE_NUM)  write index
- clause_wdata  in  2*VAR_NUM  [2V-1:V] positive-literal mask, [V-1:0] negative-literal mask
- start  in  1  one-cycle pulse; samples assignment/free (ignored while busy)
- assignment  in  VAR_NUM  variable values (meaningful where free=0)
- free  in  VAR_NUM  1 = variable unassigned
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse, result valid
- implication  out  VAR_NUM  mask of variables implied this run
- impl_value  out  VAR_NUM  implied values (valid where implication=1)
- implication_exist  out  1  |implication
- conflict  out  1  falsified clause found
- conflict_clause  out  $clog2(CLAUSE_NUM)  index of first falsified clause
- pass_count  out  $clog2(VAR_NUM+2)  full passes executed

## Operation
- Reset: all outputs 0, store entries invalid, state IDLE.
- Clause write sets entry valid. An all-zero word marks the entry unused (treated as satisfied).
- Per clause: sat = |(pos & ~free & asg) | |(neg & ~free & ~asg); nfree = popcount((pos|neg) & free).
  - unsat & nfree==0 -> falsified
  - unsat & nfree==1 -> unit; implied var = the free literal, value = its pos bit
- Lanes beyond CLAUSE_NUM, invalid entries and unused entries are masked as satisfied.
- FSM:
  - IDLE: on start, load working asg/free, clear implication/impl_value/conflict/pass_count, ptr=0, changed=0 -> SCAN.
  - SCAN, any lane falsified: conflict=1, conflict_clause = lowest falsified lane index -> DONE.
  - SCAN, else any lane unit: apply the lowest-index unit only (free bit cleared, asg bit set, implication/impl_value bits set), changed=1, ptr held, so the group is re-evaluated next cycle.
  - SCAN, else not last group: ptr += LANES.
  - SCAN, else last group: pass_count++; if changed then changed=0, ptr=0, stay in SCAN; else -> DONE.
  - DONE: done=1 for one cycle -> IDLE. Outputs hold until the next start.
- Conflict takes priority over unit in the same cycle. Conflict ends the run; implications found earlier remain reported.
- Termination guaranteed: at most VAR_NUM implications, so pass_count <= VAR_NUM+1.

## Timing
- start sampled at edge N; busy=1 from N+1.
- Run with no implications: G = ceil(CLAUSE_NUM/LANES) SCAN cycles, then done. Start-to-done latency is G+2 edges.
- Each implication adds one SCAN cycle. Each extra pass adds G.
- Outputs registered; done, busy and results change on the same edge.
- Reset low mid-run: next edge -> IDLE, all outputs 0, store invalidated.
- Simultaneous clause_we and start in IDLE: the write lands and start uses the new contents.

## Configuration
- BCP_TRAIL_EN defined: adds an implication trail of depth VAR_NUM, built on the bcp_trail_fifo sub-module.
  - Each applied implication pushes {var index, value, antecedent clause index}.
  - Added ports: trail_valid out, trail_data out, trail_ready in. The trail is readable after done.
  - start clears the trail.
- Undefined: no trail logic and no trail ports; mask outputs only.

## Structure
- Package bcp_pkg: clause literal-field slicing constants, FSM state enum (IDLE, SCAN, DONE), trail entry struct.
- Clause evaluator (sat/nfree/unit-index) as a function in bcp_pkg, instantiated per lane.
- Sub-module bcp_trail_fifo, present only under BCP_TRAIL_EN.

## Test plan
All scenarios use defaults VAR_NUM=8, CLAUSE_NUM=8, LANES=2.
- Store[0]=0xE000, asg=0x00, free=0x20, start -> implication=0x20, impl_value=0x20, implication_exist=1, conflict=0, pass_count=2.
- Same clause, free=0x00 -> conflict=1, conflict_clause=0, implication=0x00, done 3 edges after start.
- Chain: store[0]=0x0402, store[5]=0x0201, asg=0x01, free=0xFE -> implication=0x06, impl_value=0x06, pass_count=3, conflict=0.
- Same-group clash: store[0]=0x0800, store[1]=0x0008, free=0x08 -> x3 implied =1 from lane 0, then conflict=1, conflict_clause=1.
- All satisfied: store[0..7]=0x0100, asg=0x01, free=0x00 -> done exactly 6 edges after start, implication_exist=0, pass_count=1.
- Reset low during SCAN -> next edge busy=0, all outputs 0. A start without reloading clauses -> no implications, no conflict.
